// File: rtl/scanner_ctrl_if.sv
// Control and status bundle between a scanner sequencer and the logic that commands it.
interface scanner_ctrl_if;
  logic       start;
  logic       xfer_req;
  logic       flush_req;
  logic [2:0] state;
  logic [3:0] fill;
  logic       wake_peer;
  logic       done;

  modport slave (
    input  start, xfer_req, flush_req,
    output state, fill, wake_peer, done
  );

  modport master (
    output start, xfer_req, flush_req,
    input  state, fill, wake_peer, done
  );
endinterface

// File: rtl/scanner_ctrl.sv
// Scanner unit sequencer: low-power, warm-up, scan, idle, then transfer or flush of the buffer.
// Fill is tracked in tenths; wake_peer and done are single-cycle registered pulses.
module scanner_ctrl #(
  parameter int WARMUP_CYC   = 3,
  parameter int FULL_LEVEL   = 10,
  parameter int WAKE_LEVEL   = 8,
  parameter int IDLE_TIMEOUT = 15,
  parameter int FLUSH_STEP   = 2
) (
  input  logic           clk,
  input  logic           reset,
  scanner_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    S_LOWPOWER = 3'b000,
    S_STANDBY  = 3'b001,
    S_SCANNING = 3'b010,
    S_IDLE     = 3'b011,
    S_XFER     = 3'b100,
    S_FLUSH    = 3'b101
  } state_t;

  localparam logic [3:0] WARM_LAST = 4'(WARMUP_CYC - 1);
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [3:0] FULL      = 4'(FULL_LEVEL);
  localparam logic [3:0] WAKE      = 4'(WAKE_LEVEL);
  localparam logic [3:0] STEP      = 4'(FLUSH_STEP);

  state_t     state_q;
  logic [3:0] fill_q;
  logic       wake_q;
  logic       done_q;
  logic [3:0] warm_q;
  logic [7:0] idle_q;

  logic [3:0] fill_inc_d;
  logic [3:0] fill_dec_d;
  logic [3:0] fill_flush_d;

  // Candidate fill values; the decrements saturate at zero so a drain can never wrap.
  always_comb begin
    fill_inc_d   = fill_q + 4'd1;
    fill_dec_d   = (fill_q == 4'd0) ? 4'd0 : fill_q - 4'd1;
    fill_flush_d = (fill_q > STEP) ? fill_q - STEP : 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOWPOWER;
      fill_q  <= 4'd0;
      wake_q  <= 1'b0;
      done_q  <= 1'b0;
      warm_q  <= 4'd0;
      idle_q  <= 8'd0;
    end else begin
      wake_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_LOWPOWER: begin
          if (bus.start) begin
            state_q <= S_STANDBY;
            warm_q  <= 4'd0;
            fill_q  <= 4'd0;
          end
        end
        S_STANDBY: begin
          if (warm_q == WARM_LAST) state_q <= S_SCANNING;
          else                     warm_q  <= warm_q + 4'd1;
        end
        S_SCANNING: begin
          fill_q <= fill_inc_d;
          if (fill_inc_d == WAKE) wake_q <= 1'b1;
          if (fill_inc_d == FULL) begin
            state_q <= S_IDLE;
            idle_q  <= 8'd0;
          end
        end
        // Explicit requests outrank the timeout even on the timeout cycle itself.
        S_IDLE: begin
          if (bus.xfer_req)            state_q <= S_XFER;
          else if (bus.flush_req)      state_q <= S_FLUSH;
          else if (idle_q == IDLE_LAST) state_q <= S_FLUSH;
          else                         idle_q  <= idle_q + 8'd1;
        end
        S_XFER: begin
          fill_q <= fill_dec_d;
          if (fill_dec_d == 4'd0) begin
            state_q <= S_LOWPOWER;
            done_q  <= 1'b1;
          end
        end
        S_FLUSH: begin
          fill_q <= fill_flush_d;
          if (fill_flush_d == 4'd0) begin
            state_q <= S_LOWPOWER;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_LOWPOWER;
          fill_q  <= 4'd0;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.fill      = fill_q;
  assign bus.wake_peer = wake_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_scanner_ctrl.sv
// Scoreboard bench for scanner_ctrl: two instances (flush step 2 and 3) driven cycle by cycle.
module tb_scanner_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scanner_ctrl_if ifa ();
  scanner_ctrl_if ifb ();

  scanner_ctrl #(.FLUSH_STEP(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  scanner_ctrl #(.FLUSH_STEP(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct packed {
    logic       isb;
    logic [7:0] ph;
    logic [2:0] st;
    logic [3:0] fl;
    logic       wk;
    logic       dn;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_chk = 0;
  int   n_err = 0;
  int   ph    = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the outputs produced by each edge against the expectation queued one cycle earlier.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      if (m.isb) begin
        chk($sformatf("p%0d.b.state", m.ph), 8'(ifb.state), 8'(m.st));
        chk($sformatf("p%0d.b.fill", m.ph), 8'(ifb.fill), 8'(m.fl));
        chk($sformatf("p%0d.b.wake", m.ph), 8'(ifb.wake_peer), 8'(m.wk));
        chk($sformatf("p%0d.b.done", m.ph), 8'(ifb.done), 8'(m.dn));
      end else begin
        chk($sformatf("p%0d.a.state", m.ph), 8'(ifa.state), 8'(m.st));
        chk($sformatf("p%0d.a.fill", m.ph), 8'(ifa.fill), 8'(m.fl));
        chk($sformatf("p%0d.a.wake", m.ph), 8'(ifa.wake_peer), 8'(m.wk));
        chk($sformatf("p%0d.a.done", m.ph), 8'(ifa.done), 8'(m.dn));
      end
    end
  end

  task automatic drive(input logic isb, input logic s, input logic x, input logic f,
                       input logic [2:0] est, input logic [3:0] efl,
                       input logic ewk, input logic edn);
    @(posedge clk);
    #2;
    if (isb) begin
      ifb.start = s; ifb.xfer_req = x; ifb.flush_req = f;
    end else begin
      ifa.start = s; ifa.xfer_req = x; ifa.flush_req = f;
    end
    q.push_back('{isb: isb, ph: 8'(ph), st: est, fl: efl, wk: ewk, dn: edn});
  endtask

  // start pulse, 3 STANDBY cycles, 10 SCANNING cycles (wake at fill 8), IDLE with fill 10.
  task automatic run_to_idle(input logic isb, input logic noise);
    drive(isb, 1'b1, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0, 1'b0);
    repeat (2) drive(isb, noise, noise, noise, 3'd1, 4'd0, 1'b0, 1'b0);
    drive(isb, noise, noise, noise, 3'd2, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++)
      drive(isb, noise, noise, noise, 3'd2, 4'(i), (i == 8), 1'b0);
    drive(isb, noise, noise, noise, 3'd3, 4'd10, 1'b0, 1'b0);
  endtask

  task automatic xfer_drain(input logic isb);
    for (int i = 9; i >= 1; i--)
      drive(isb, 1'b1, 1'b0, 1'b1, 3'd4, 4'(i), 1'b0, 1'b0);
    drive(isb, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    drive(isb, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic flush_drain(input logic isb, input int step);
    int f;
    int nf;
    f = 10;
    while (f > 0) begin
      nf = (f > step) ? f - step : 0;
      if (nf == 0) drive(isb, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
      else         drive(isb, 1'b0, 1'b0, 1'b0, 3'd5, 4'(nf), 1'b0, 1'b0);
      f = nf;
    end
    drive(isb, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    ifa.start = 1'b0; ifa.xfer_req = 1'b0; ifa.flush_req = 1'b0;
    ifb.start = 1'b0; ifb.xfer_req = 1'b0; ifb.flush_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a.state", 8'(ifa.state), 8'd0);
    chk("rst.a.fill", 8'(ifa.fill), 8'd0);
    chk("rst.a.wake", 8'(ifa.wake_peer), 8'd0);
    chk("rst.a.done", 8'(ifa.done), 8'd0);
    chk("rst.b.state", 8'(ifb.state), 8'd0);
    chk("rst.b.fill", 8'(ifb.fill), 8'd0);
    #3 reset = 1'b0;

    // Asynchronous reset in the middle of SCANNING at fill 5.
    ph = 1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'(i), 1'b0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst.state", 8'(ifa.state), 8'd0);
    chk("midrst.fill", 8'(ifa.fill), 8'd0);
    @(posedge clk);
    #1;
    chk("midrst.done", 8'(ifa.done), 8'd0);
    chk("midrst.wake", 8'(ifa.wake_peer), 8'd0);
    #2 reset = 1'b0;

    // Full scan with ignored inputs, start ignored in IDLE, then transfer.
    ph = 2;
    run_to_idle(1'b0, 1'b1);
    ph = 3;
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'd10, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 4'd10, 1'b0, 1'b0);
    xfer_drain(1'b0);

    // Both requests together: transfer wins.
    ph = 4;
    run_to_idle(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 4'd10, 1'b0, 1'b0);
    xfer_drain(1'b0);

    // Idle timeout leads to a flush with step 2.
    ph = 5;
    run_to_idle(1'b0, 1'b0);
    repeat (14) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd10, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 4'd10, 1'b0, 1'b0);
    flush_drain(1'b0, 2);

    // Explicit flush request.
    ph = 6;
    run_to_idle(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 4'd10, 1'b0, 1'b0);
    flush_drain(1'b0, 2);

    // Transfer request on the timeout cycle beats the timeout.
    ph = 7;
    run_to_idle(1'b0, 1'b0);
    repeat (14) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd10, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 4'd10, 1'b0, 1'b0);
    xfer_drain(1'b0);

    // Second instance: timeout flush with step 3 saturates at zero.
    ph = 8;
    run_to_idle(1'b1, 1'b0);
    repeat (14) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'd10, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 4'd10, 1'b0, 1'b0);
    flush_drain(1'b1, 3);

    @(posedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
